// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: step encodings, square index width
// and the debounce FSM state type.
package game_pkg;

    localparam int SQ_W = 3;

    localparam logic [2:0] STEP_IDLE  = 3'd0;
    localparam logic [2:0] STEP_PICK1 = 3'd1;
    localparam logic [2:0] STEP_CHECK = 3'd2;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_ARM,
        DB_HELD,
        DB_DISARM
    } db_state_t;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer plus a four-state debounce FSM with a saturating counter.
// 'rise' flags the accept decision combinationally; 'level' is the registered clean level.
module debouncer
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    input  logic hold_off,
    output logic level,
    output logic rise
);

    // The IDLE->ARM detection cycle counts as the first stable cycle, so the
    // accept fires when the counter reaches DEBOUNCE_CYCLES-2 inside ARM.
    localparam logic [CNT_W-1:0] LAST    = CNT_W'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1, sync2;
    db_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             supp, supp_nx;
    logic             level_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        supp_nx  = supp;
        rise     = 1'b0;
        case (state)
            DB_IDLE: begin
                supp_nx = 1'b0;
                if (sync2) begin
                    state_nx = DB_ARM;
                    cnt_nx   = '0;
                end
            end
            DB_ARM: begin
                if (!sync2) begin
                    state_nx = DB_IDLE;
                end else if (cnt >= LAST) begin
                    state_nx = DB_HELD;
                    rise     = 1'b1;
                    supp_nx  = hold_off;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DB_HELD: begin
                if (!sync2) begin
                    state_nx = DB_DISARM;
                    cnt_nx   = '0;
                end
            end
            DB_DISARM: begin
                if (sync2) begin
                    state_nx = DB_HELD;
                end else if (cnt >= LAST) begin
                    state_nx = DB_IDLE;
                    supp_nx  = 1'b0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = DB_IDLE;
        endcase
        level_nx = ((state_nx == DB_HELD) || (state_nx == DB_DISARM)) && !supp_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= DB_IDLE;
            cnt   <= '0;
            supp  <= 1'b0;
            level <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            state <= state_nx;
            cnt   <= cnt_nx;
            supp  <= supp_nx;
            level <= level_nx;
        end
    end

endmodule

// File: rtl/button_select.sv
// Button conditioning and square-select capture for the step counter.
// Optional duplicate-pick rejection is enabled with `define BTN_SELECT_DUP_REJECT_EN.
module button_select
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_raw,
    input  logic [1:0]      sw,
    input  logic [2:0]      step,
    output logic            btn_clean,
    output logic            press_pulse,
    output logic [SQ_W-1:0] variety,
    output logic [SQ_W-1:0] match,
    output logic            reject
);

    logic [2:0]      step_s1, step_s;
    logic            accept;
    logic            dup;
    logic [SQ_W-1:0] pick;

    assign pick = {1'b0, sw};

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debouncer (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (btn_raw),
        .hold_off(dup),
        .level   (btn_clean),
        .rise    (accept)
    );

`ifdef BTN_SELECT_DUP_REJECT_EN
    // A second pick equal to the first would make the check step trivially pass.
    assign dup = (step_s == STEP_PICK1) && (pick == variety);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject <= 1'b0;
        end else begin
            reject <= accept && dup;
        end
    end
`else
    assign dup    = 1'b0;
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1     <= STEP_IDLE;
            step_s      <= STEP_IDLE;
            press_pulse <= 1'b0;
            variety     <= '0;
            match       <= '0;
        end else begin
            step_s1     <= step;
            step_s      <= step_s1;
            press_pulse <= accept && !dup;
            if (accept && !dup) begin
                if (step_s == STEP_IDLE) begin
                    variety <= pick;
                end else if (step_s == STEP_PICK1) begin
                    match <= pick;
                end
            end
        end
    end

endmodule
